// File: rtl/event_multiplier.sv
// Purpose : re-expands each rising edge on i_in into a burst of N clean pulses on o_out.
// Latency : i_in first sampled high at edge t gives o_out high after edge t+2.
// Backpressure: edges during a burst queue up to PEND_MAX deep; excess edges are dropped with a one-cycle o_overflow.
//
// Ports:
//   i_clk      - single clock, all state updates on its rising edge
//   i_rst      - synchronous active-high reset
//   i_in       - asynchronous event input, a rising edge is one event
//   o_out      - registered pulse-burst output (high while the FSM is in HIGH)
//   o_busy     - high while a burst is running or events are queued
//   o_overflow - one-cycle pulse when an event is dropped
module event_multiplier #(
    parameter int N        = 2,
    parameter int PULSE_W  = 1,
    parameter int GAP_W    = 1,
    parameter int PEND_MAX = 3
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_in,
    output logic o_out,
    output logic o_busy,
    output logic o_overflow
);

    localparam int CW       = (N > 1) ? $clog2(N) : 1;
    localparam int PH_RANGE = (PULSE_W > GAP_W) ? PULSE_W : GAP_W;
    localparam int PHW      = (PH_RANGE > 1) ? $clog2(PH_RANGE) : 1;
    localparam int PNW      = (PEND_MAX > 0) ? $clog2(PEND_MAX + 1) : 1;

    localparam logic [CW-1:0]  CNT_LAST = CW'(N - 1);
    localparam logic [PHW-1:0] HI_LAST  = PHW'(PULSE_W - 1);
    localparam logic [PHW-1:0] LO_LAST  = PHW'(GAP_W - 1);
    localparam logic [PNW-1:0] PEND_TOP = PNW'(PEND_MAX);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        LOW  = 2'd2
    } state_t;

    logic           r_in_s1;
    logic           r_in_s2;
    logic           r_evt;
    state_t         r_state;
    logic [CW-1:0]  r_pulse_cnt;
    logic [PHW-1:0] r_phase;
    logic [PNW-1:0] r_pend;
    logic           r_out;
    logic           r_overflow;

    logic w_edge;
    logic w_burst_done;
    logic w_queue_evt;
    logic w_room;

    // Synchroniser keeps loading during reset so a level already high
    // when reset releases is not mistaken for a fresh edge.
    always_ff @(posedge i_clk) begin
        r_in_s1 <= i_in;
        r_in_s2 <= r_in_s1;
    end

    assign w_edge = r_in_s1 & ~r_in_s2;

    // Last gap cycle of the last pulse: the only cycle where an event can
    // start the next burst directly instead of going through the queue.
    assign w_burst_done = (r_state == LOW) && (r_phase == LO_LAST) &&
                          (r_pulse_cnt == CNT_LAST);

    assign w_queue_evt = r_evt && (r_state != IDLE) && !w_burst_done;

    // Pending never exceeds PEND_MAX, so inequality means there is room;
    // with PEND_MAX=0 pending stays 0 and there is never room.
    assign w_room = (r_pend != PEND_TOP);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_evt       <= 1'b0;
            r_state     <= IDLE;
            r_pulse_cnt <= '0;
            r_phase     <= '0;
            r_pend      <= '0;
            r_out       <= 1'b0;
            r_overflow  <= 1'b0;
        end else begin
            // Registered edge strobe: together with the two synchroniser
            // flops this sets the two-clock input-to-output latency.
            r_evt      <= w_edge;
            r_overflow <= 1'b0;

            case (r_state)
                IDLE: begin
                    if (r_evt) begin
                        r_state     <= HIGH;
                        r_out       <= 1'b1;
                        r_pulse_cnt <= '0;
                        r_phase     <= '0;
                    end
                end

                HIGH: begin
                    if (r_phase == HI_LAST) begin
                        r_state <= LOW;
                        r_out   <= 1'b0;
                        r_phase <= '0;
                    end else begin
                        r_phase <= r_phase + 1'b1;
                    end
                end

                LOW: begin
                    if (r_phase != LO_LAST) begin
                        r_phase <= r_phase + 1'b1;
                    end else if (r_pulse_cnt != CNT_LAST) begin
                        r_pulse_cnt <= r_pulse_cnt + 1'b1;
                        r_state     <= HIGH;
                        r_out       <= 1'b1;
                        r_phase     <= '0;
                    end else if (r_pend != '0) begin
                        // A new event in this cycle replaces the one consumed,
                        // so pending only drops when no event arrives.
                        r_state     <= HIGH;
                        r_out       <= 1'b1;
                        r_pulse_cnt <= '0;
                        r_phase     <= '0;
                        if (!r_evt) begin
                            r_pend <= r_pend - 1'b1;
                        end
                    end else if (r_evt) begin
                        r_state     <= HIGH;
                        r_out       <= 1'b1;
                        r_pulse_cnt <= '0;
                        r_phase     <= '0;
                    end else begin
                        r_state <= IDLE;
                    end
                end

                default: begin
                    r_state <= IDLE;
                    r_out   <= 1'b0;
                end
            endcase

            // Exclusive with the decrement above (that path is burst-done only).
            if (w_queue_evt) begin
                if (w_room) begin
                    r_pend <= r_pend + 1'b1;
                end else begin
                    r_overflow <= 1'b1;
                end
            end
        end
    end

    assign o_out      = r_out;
    assign o_busy     = (r_state != IDLE) || (r_pend != '0);
    assign o_overflow = r_overflow;

endmodule

// File: tb/tb_event_multiplier.sv
module tb_event_multiplier;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] din;
    logic [3:0] dout;
    logic [3:0] dbusy;
    logic [3:0] dovf;

    always #5 clk = ~clk;

    event_multiplier #(.N(3), .PULSE_W(1), .GAP_W(1), .PEND_MAX(3)) u_a (
        .i_clk(clk), .i_rst(rst), .i_in(din[0]),
        .o_out(dout[0]), .o_busy(dbusy[0]), .o_overflow(dovf[0]));
    event_multiplier #(.N(2), .PULSE_W(2), .GAP_W(3), .PEND_MAX(1)) u_b (
        .i_clk(clk), .i_rst(rst), .i_in(din[1]),
        .o_out(dout[1]), .o_busy(dbusy[1]), .o_overflow(dovf[1]));
    event_multiplier #(.N(4), .PULSE_W(1), .GAP_W(2), .PEND_MAX(3)) u_c (
        .i_clk(clk), .i_rst(rst), .i_in(din[2]),
        .o_out(dout[2]), .o_busy(dbusy[2]), .o_overflow(dovf[2]));
    event_multiplier #(.N(1), .PULSE_W(2), .GAP_W(2), .PEND_MAX(0)) u_d (
        .i_clk(clk), .i_rst(rst), .i_in(din[3]),
        .o_out(dout[3]), .o_busy(dbusy[3]), .o_overflow(dovf[3]));

    // Parameters of the four instances, for the reference model.
    int pN  [4] = '{3, 2, 4, 1};
    int pPW [4] = '{1, 2, 1, 2};
    int pGW [4] = '{1, 3, 2, 2};
    int pPM [4] = '{3, 1, 3, 0};

    int errors;
    int checks;
    int cyc;

    // Reference model: a burst is described by its start cycle; output
    // level follows from (cycle - start) mod period.
    bit m_act  [4];
    int m_st   [4];
    int m_end  [4];
    int m_pend [4];
    bit m_ovf  [4];
    bit m_ev   [4];
    bit m_h1   [4];
    bit m_h2   [4];

    int npulse [4];
    int novf   [4];
    bit prev_out [4];

    typedef struct {
        logic in;
        logic out;
        logic busy;
    } vec_t;
    vec_t vecs [26];

    task automatic chk(input string nm, input int inst, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s inst=%0d cycle=%0d got=%0d expected=%0d", nm, inst, cyc, got, exp);
        end
    endtask

    function automatic logic exp_out(input int i);
        return m_act[i] && (((cyc - m_st[i]) % (pPW[i] + pGW[i])) < pPW[i]);
    endfunction

    task automatic start_burst(input int i);
        m_act[i] = 1'b1;
        m_st[i]  = cyc;
        m_end[i] = cyc + pN[i] * (pPW[i] + pGW[i]) - 1;
    endtask

    task automatic model_step(input logic r, input logic [3:0] ins);
        for (int i = 0; i < 4; i++) begin
            bit ev;
            bit nev;
            ev  = m_ev[i];
            nev = m_h1[i] & ~m_h2[i];
            if (r) begin
                m_act[i]  = 1'b0;
                m_pend[i] = 0;
                m_ovf[i]  = 1'b0;
                nev       = 1'b0;
            end else begin
                m_ovf[i] = 1'b0;
                if (m_act[i] && (cyc - 1 == m_end[i])) begin
                    if (m_pend[i] > 0) begin
                        start_burst(i);
                        if (!ev) m_pend[i]--;
                    end else if (ev) begin
                        start_burst(i);
                    end else begin
                        m_act[i] = 1'b0;
                    end
                end else if (m_act[i]) begin
                    if (ev) begin
                        if (m_pend[i] < pPM[i]) m_pend[i]++;
                        else m_ovf[i] = 1'b1;
                    end
                end else if (ev) begin
                    start_burst(i);
                end
            end
            m_ev[i] = nev;
            m_h2[i] = m_h1[i];
            m_h1[i] = ins[i];
        end
    endtask

    task automatic tick(input logic r, input logic [3:0] ins);
        rst = r;
        din = ins;
        @(posedge clk);
        cyc++;
        model_step(r, ins);
        #1;
        for (int i = 0; i < 4; i++) begin
            chk("out", i, 32'(dout[i]), 32'(exp_out(i)));
            chk("busy", i, 32'(dbusy[i]), 32'(m_act[i] || (m_pend[i] > 0)));
            chk("overflow", i, 32'(dovf[i]), 32'(m_ovf[i]));
            if (dout[i] === 1'b1 && !prev_out[i]) npulse[i]++;
            if (dovf[i] === 1'b1) novf[i]++;
            prev_out[i] = (dout[i] === 1'b1);
        end
    endtask

    task automatic clear_counts();
        for (int i = 0; i < 4; i++) begin
            npulse[i] = 0;
            novf[i]   = 0;
        end
    endtask

    task automatic run_pattern(input int lane, input logic [15:0] pat, input int n);
        for (int k = 0; k < n; k++) begin
            logic [3:0] v;
            v = 4'b0;
            if (k < 16) v[lane] = pat[k];
            tick(1'b0, v);
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        cyc    = 0;
        rst    = 1'b1;
        din    = 4'b0;
        for (int i = 0; i < 4; i++) begin
            m_act[i] = 0; m_st[i] = 0; m_end[i] = 0; m_pend[i] = 0;
            m_ovf[i] = 0; m_ev[i] = 0; m_h1[i] = 0; m_h2[i] = 0;
            prev_out[i] = 0;
        end
        clear_counts();

        // Instance A, single edge then an edge queued mid-burst.
        vecs[0]  = '{1'b1, 1'b0, 1'b0}; vecs[1]  = '{1'b1, 1'b0, 1'b0};
        vecs[2]  = '{1'b0, 1'b1, 1'b1}; vecs[3]  = '{1'b0, 1'b0, 1'b1};
        vecs[4]  = '{1'b0, 1'b1, 1'b1}; vecs[5]  = '{1'b0, 1'b0, 1'b1};
        vecs[6]  = '{1'b0, 1'b1, 1'b1}; vecs[7]  = '{1'b0, 1'b0, 1'b1};
        vecs[8]  = '{1'b0, 1'b0, 1'b0}; vecs[9]  = '{1'b0, 1'b0, 1'b0};
        vecs[10] = '{1'b1, 1'b0, 1'b0}; vecs[11] = '{1'b0, 1'b0, 1'b0};
        vecs[12] = '{1'b0, 1'b1, 1'b1}; vecs[13] = '{1'b1, 1'b0, 1'b1};
        vecs[14] = '{1'b0, 1'b1, 1'b1}; vecs[15] = '{1'b0, 1'b0, 1'b1};
        vecs[16] = '{1'b0, 1'b1, 1'b1}; vecs[17] = '{1'b0, 1'b0, 1'b1};
        vecs[18] = '{1'b0, 1'b1, 1'b1}; vecs[19] = '{1'b0, 1'b0, 1'b1};
        vecs[20] = '{1'b0, 1'b1, 1'b1}; vecs[21] = '{1'b0, 1'b0, 1'b1};
        vecs[22] = '{1'b0, 1'b1, 1'b1}; vecs[23] = '{1'b0, 1'b0, 1'b1};
        vecs[24] = '{1'b0, 1'b0, 1'b0}; vecs[25] = '{1'b0, 1'b0, 1'b0};

        for (int k = 0; k < 3; k++) tick(1'b1, 4'b0);
        for (int k = 0; k < 2; k++) tick(1'b0, 4'b0);

        for (int k = 0; k < 26; k++) begin
            tick(1'b0, {3'b0, vecs[k].in});
            chk("tbl_out", 0, 32'(dout[0]), 32'(vecs[k].out));
            chk("tbl_busy", 0, 32'(dbusy[0]), 32'(vecs[k].busy));
            chk("tbl_overflow", 0, 32'(dovf[0]), 32'd0);
        end
        for (int k = 0; k < 5; k++) tick(1'b0, 4'b0);

        // Instance B: one queued, two dropped -> two bursts.
        clear_counts();
        run_pattern(1, 16'b0000_0010_0100_0101, 40);
        chk("b_drop_pulses", 1, 32'(npulse[1]), 32'd4);
        chk("b_drop_overflows", 1, 32'(novf[1]), 32'd2);

        // Instance B: edge lands on the burst-done cycle while pending=1.
        clear_counts();
        run_pattern(1, 16'b0000_0100_1000_1001, 40);
        chk("b_coincide_pulses", 1, 32'(npulse[1]), 32'd6);
        chk("b_coincide_overflows", 1, 32'(novf[1]), 32'd0 + 32'd1);

        // Instance C: reset during the second pulse.
        clear_counts();
        tick(1'b0, 4'b0100);
        for (int k = 0; k < 5; k++) tick(1'b0, 4'b0);
        chk("c_second_pulse", 2, 32'(dout[2]), 32'd1);
        tick(1'b1, 4'b0);
        chk("c_rst_out", 2, 32'(dout[2]), 32'd0);
        chk("c_rst_busy", 2, 32'(dbusy[2]), 32'd0);
        clear_counts();
        for (int k = 0; k < 10; k++) tick(1'b0, 4'b0);
        chk("c_no_pulse_after_rst", 2, 32'(npulse[2]), 32'd0);
        tick(1'b0, 4'b0100);
        for (int k = 0; k < 15; k++) tick(1'b0, 4'b0);
        chk("c_full_burst", 2, 32'(npulse[2]), 32'd4);

        // Instance C: input held high across reset release.
        tick(1'b1, 4'b0);
        for (int k = 0; k < 3; k++) tick(1'b1, 4'b0100);
        clear_counts();
        for (int k = 0; k < 12; k++) tick(1'b0, 4'b0100);
        chk("c_hold_no_pulse", 2, 32'(npulse[2]), 32'd0);
        chk("c_hold_busy", 2, 32'(dbusy[2]), 32'd0);
        tick(1'b0, 4'b0);
        tick(1'b0, 4'b0);
        for (int k = 0; k < 16; k++) tick(1'b0, 4'b0100);
        chk("c_hold_then_edge", 2, 32'(npulse[2]), 32'd4);
        tick(1'b0, 4'b0);

        // Instance D (N=1, no queue): edge in last gap cycle vs one earlier.
        clear_counts();
        run_pattern(3, 16'b0000_0000_0001_0001, 20);
        chk("d_last_gap_pulses", 3, 32'(npulse[3]), 32'd2);
        chk("d_last_gap_overflow", 3, 32'(novf[3]), 32'd0);
        clear_counts();
        run_pattern(3, 16'b0000_0000_0000_1001, 20);
        chk("d_early_pulses", 3, 32'(npulse[3]), 32'd1);
        chk("d_early_overflow", 3, 32'(novf[3]), 32'd1);

        // Random stimulus on all lanes with occasional resets.
        for (int k = 0; k < 1500; k++) begin
            logic [3:0] v;
            logic       r;
            for (int i = 0; i < 4; i++) begin
                v[i] = ($urandom_range(0, 3) == 0) ? ~din[i] : din[i];
            end
            r = ($urandom_range(0, 199) == 0);
            tick(r, v);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/event_multiplier.md
Name: event_multiplier

Overview:
- Inverse of the event divider: every rising edge on `in` becomes a burst of N clean output pulses on `out`.
- Sits where a divided event stream must be re-expanded, e.g. regenerating a full-rate strobe from a decimated one.
- Input is asynchronous and gets the same two-flop synchroniser and rising-edge detect the divider uses.
- Edges that arrive during a burst are queued up to a bounded depth; excess edges are dropped and flagged.

Parameters:
- N, 2, output pulses per input event; legal range >= 1.
- PULSE_W, 1, high cycles per output pulse; >= 1.
- GAP_W, 1, low cycles after each output pulse, including the last one of a burst; >= 1.
- PEND_MAX, 3, maximum queued events; >= 0. 0 disables queueing.

Ports:
- clk  input  1  single clock; all state updates on its rising edge.
- rst  input  1  reset, synchronous, active-high.
- in  input  1  asynchronous event input; a rising edge is one event.
- out  output  1  registered pulse-burst output.
- busy  output  1  1 while state != IDLE or pending != 0.
- overflow  output  1  one-cycle pulse when an event is dropped.

Behaviour:
- Synchroniser: in_s1 <= in; in_s2 <= in_s1; edge = in_s1 & ~in_s2.
- During rst the synchroniser flops still load `in`, so `in` held high across reset release is not an event.
- While rst=1 at a clock edge:
  - state <= IDLE; pulse, phase and pending counters <= 0.
  - out <= 0; overflow <= 0.
  - busy reads 0 from the cycle after.
- Counter widths: $clog2 of each range, minimum 1 bit. No wrap: counters are bounded by the FSM, and pending saturates.
- FSM states:
  - IDLE: on edge -> HIGH, pulse_cnt=0, phase=0.
  - HIGH: out=1 for PULSE_W cycles, then -> LOW, phase=0.
  - LOW: out=0 for GAP_W cycles, then:
    - pulse_cnt+1 < N: pulse_cnt++ and -> HIGH.
    - burst done, pending>0: pending--, start new burst (-> HIGH, pulse_cnt=0).
    - burst done, pending=0, edge this cycle: start new burst directly; pending unchanged.
    - otherwise -> IDLE.
- out is registered and equals (state==HIGH).
- Latency: `in` first sampled 1 at clock edge t gives out=1 after edge t+2, i.e. two clocks of latency.
- Edge while busy, except the burst-done cycle above:
  - pending < PEND_MAX: pending++.
  - pending == PEND_MAX: event dropped; overflow=1 for exactly that cycle; pending unchanged.
- Edge coinciding with a pending decrement at burst end: net pending unchanged; no overflow.
- PEND_MAX=0: every edge while state != IDLE (excluding the burst-done case) raises overflow.
- Output pulses are never shortened or merged. Consecutive bursts are always separated by at least GAP_W low cycles.
- Mid-operation reset aborts the burst immediately. out=0 after the reset edge; queued events are discarded.
- Only rising edges count; `in` level and duration are otherwise ignored.

Test Plan:
- N=3, PULSE_W=1, GAP_W=1, PEND_MAX=3; single edge at cycle 0 -> out = 0,0,1,0,1,0,1,0 over cycles 0..7; busy high cycles 2..7, low from 8; overflow never.
- Same config; second edge at cycle 3 -> pending=1; second burst of 3 pulses starts immediately after the first burst's final gap (out high cycles 8,10,12); busy falls only after the second burst.
- N=2, PULSE_W=2, GAP_W=3, PEND_MAX=1; four edges spaced 4 cycles apart starting mid-burst -> first queued, next two dropped with one overflow pulse each; total output pulses = 4 (two bursts), each 2 cycles wide with 3-cycle gaps.
- N=4; assert rst during the second pulse -> out=0 from the next cycle; no further pulses; busy=0; a fresh edge after release gives a full 4-pulse burst.
- Hold `in`=1 before and through rst release -> no output; later 1->0->1 on `in` -> one N-pulse burst.
- N=1, PEND_MAX=0; edge arrives exactly in the last GAP cycle -> new burst starts with no overflow. An edge one cycle earlier -> overflow pulse and no second burst.
